// File: rtl/hw1_vector_sweeper_if.sv
//------------------------------------------------------------------------------
// Module      : hw1_vector_sweeper_if
// Description : Bundle between the HW1 vector sweeper and its environment:
//               stimulus vector, function-under-test outputs, and results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hw1_vector_sweeper_if;
  logic        start;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        z1;
  logic        z2;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic        fail_valid;
  logic [3:0]  first_fail;

  // Environment side: issues start and returns the function outputs
  modport master (
    output start, z1, z2,
    input  A, B, C, D, busy, done, truth_table, mismatch_cnt, fail_valid, first_fail
  );

  // Sweeper side
  modport slave (
    input  start, z1, z2,
    output A, B, C, D, busy, done, truth_table, mismatch_cnt, fail_valid, first_fail
  );
endinterface

`default_nettype wire

// File: rtl/hw1_vector_sweeper.sv
//------------------------------------------------------------------------------
// Module      : hw1_vector_sweeper
// Description : Walks ABCD through 0000..1111, holding each vector for
//               HOLD_CYCLES cycles, samples z1/z2 on the last hold cycle and
//               accumulates truth table, mismatch count and first failure.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hw1_vector_sweeper #(
  parameter int HOLD_CYCLES = 100
) (
  input  wire logic             clk,
  input  wire logic             rst,
  hw1_vector_sweeper_if.slave   bus
);

  // A single-cycle hold still needs a 1-bit counter that stays at zero
  localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_vec;
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_tt;
  logic [4:0]          r_mcnt;
  logic                r_fv;
  logic [3:0]          r_ff;

  logic                w_sample;
  logic                w_miss;

  // Sample on the last cycle of each hold window; compare the two implementations
  always_comb begin
    w_sample = (r_hold == c_HOLD_LAST);
    w_miss   = bus.z1 ^ bus.z2;
  end

  // Sweep controller: state, vector/hold counters and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 4'd0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= 16'h0000;
      r_mcnt  <= 5'd0;
      r_fv    <= 1'b0;
      r_ff    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A start from DONE is identical to one from IDLE: results clear
          if (bus.start) begin
            r_state <= S_SWEEP;
            r_vec   <= 4'd0;
            r_hold  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_tt    <= 16'h0000;
            r_mcnt  <= 5'd0;
            r_fv    <= 1'b0;
            r_ff    <= 4'd0;
          end
        end
        S_SWEEP: begin
          // start is deliberately ignored here
          if (w_sample) begin
            r_tt[r_vec] <= bus.z1;
            if (w_miss) begin
              r_mcnt <= r_mcnt + 5'd1;
              if (!r_fv) begin
                r_fv <= 1'b1;
                r_ff <= r_vec;
              end
            end
            if (r_vec == 4'd15) begin
              // Vector stays at 1111 while DONE
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec  <= r_vec + 4'd1;
              r_hold <= '0;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A            = r_vec[3];
  assign bus.B            = r_vec[2];
  assign bus.C            = r_vec[1];
  assign bus.D            = r_vec[0];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.truth_table  = r_tt;
  assign bus.mismatch_cnt = r_mcnt;
  assign bus.fail_valid   = r_fv;
  assign bus.first_fail   = r_ff;

endmodule

`default_nettype wire

// File: tb/tb_hw1_vector_sweeper.sv
//------------------------------------------------------------------------------
// Module      : tb_hw1_vector_sweeper
// Description : Scoreboard bench for hw1_vector_sweeper with HOLD_CYCLES = 4
//               and HOLD_CYCLES = 1 instances, directed and random functions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hw1_vector_sweeper;

  localparam int c_H0 = 4;
  localparam int c_H1 = 1;

  typedef struct {
    logic [15:0] tt;
    int          mcnt;
    logic        fv;
    logic [3:0]  ff;
    int          cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hw1_vector_sweeper_if if0 ();
  hw1_vector_sweeper_if if1 ();

  hw1_vector_sweeper #(.HOLD_CYCLES(c_H0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  hw1_vector_sweeper #(.HOLD_CYCLES(c_H1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Function under test: z1 = f[vec], z2 = z1 flipped wherever mask is set
  logic [15:0] f_r [2];
  logic [15:0] m_r [2];
  logic        st  [2];

  logic        w_busy [2];
  logic        w_done [2];
  logic [3:0]  w_vec  [2];
  logic [15:0] w_tt   [2];
  logic [4:0]  w_mcnt [2];
  logic        w_fv   [2];
  logic [3:0]  w_ff   [2];

  assign w_vec[0]  = {if0.A, if0.B, if0.C, if0.D};
  assign w_vec[1]  = {if1.A, if1.B, if1.C, if1.D};
  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if0.z1    = f_r[0][w_vec[0]];
  assign if0.z2    = f_r[0][w_vec[0]] ^ m_r[0][w_vec[0]];
  assign if1.z1    = f_r[1][w_vec[1]];
  assign if1.z2    = f_r[1][w_vec[1]] ^ m_r[1][w_vec[1]];
  assign w_busy[0] = if0.busy;          assign w_busy[1] = if1.busy;
  assign w_done[0] = if0.done;          assign w_done[1] = if1.done;
  assign w_tt[0]   = if0.truth_table;   assign w_tt[1]   = if1.truth_table;
  assign w_mcnt[0] = if0.mismatch_cnt;  assign w_mcnt[1] = if1.mismatch_cnt;
  assign w_fv[0]   = if0.fail_valid;    assign w_fv[1]   = if1.fail_valid;
  assign w_ff[0]   = if0.first_fail;    assign w_ff[1]   = if1.first_fail;

  int   errors = 0;
  int   checks = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  function automatic int hold_of(int k);
    return (k == 0) ? c_H0 : c_H1;
  endfunction

  // Expected results straight from the function and mismatch mask
  function automatic exp_t model(logic [15:0] f, logic [15:0] m, int h);
    exp_t e;
    e.tt     = f;
    e.mcnt   = $countones(m);
    e.fv     = (m != 16'h0);
    e.ff     = 4'd0;
    for (int v = 15; v >= 0; v--) if (m[v]) e.ff = 4'(v);
    e.cycles = 16 * h;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks the vector schedule every busy cycle and pops the
  // scoreboard entry when done rises
  int   bcnt [2] = '{0, 0};
  logic pdone[2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_busy[k]) begin
        chk($sformatf("vec_sched%0d", k), int'(w_vec[k]), bcnt[k] / hold_of(k));
        bcnt[k]++;
      end
      if (w_done[k] && !pdone[k]) begin
        exp_t e;
        logic have;
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          chk($sformatf("unexpected_done%0d", k), 1, 0);
        end else begin
          chk($sformatf("truth_table%0d", k), int'(w_tt[k]), int'(e.tt));
          chk($sformatf("mismatch_cnt%0d", k), int'(w_mcnt[k]), e.mcnt);
          chk($sformatf("fail_valid%0d", k), int'(w_fv[k]), int'(e.fv));
          if (e.fv) chk($sformatf("first_fail%0d", k), int'(w_ff[k]), int'(e.ff));
          chk($sformatf("busy_cycles%0d", k), bcnt[k], e.cycles);
          chk($sformatf("done_vec%0d", k), int'(w_vec[k]), 15);
        end
        bcnt[k] = 0;
      end
      if (!w_busy[k] && !w_done[k]) bcnt[k] = 0;
      pdone[k] = w_done[k];
    end
  end

  task automatic check_clear(int k, string tag);
    chk({tag, "_tt"}, int'(w_tt[k]), 0);
    chk({tag, "_mcnt"}, int'(w_mcnt[k]), 0);
    chk({tag, "_fv"}, int'(w_fv[k]), 0);
    chk({tag, "_ff"}, int'(w_ff[k]), 0);
  endtask

  // Pulse start for one cycle and check the start-edge response
  task automatic start_pulse(int k);
    @(posedge clk); #1;
    st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    chk($sformatf("start_busy%0d", k), int'(w_busy[k]), 1);
    chk($sformatf("start_done%0d", k), int'(w_done[k]), 0);
    chk($sformatf("start_vec%0d", k), int'(w_vec[k]), 0);
    check_clear(k, $sformatf("start_clear%0d", k));
  endtask

  task automatic wait_vec(int k, int v);
    int i;
    for (i = 0; i < 500; i++) begin
      if (w_vec[k] == 4'(v)) break;
      @(posedge clk); #1;
    end
    if (i == 500) chk($sformatf("wait_vec%0d_timeout", k), int'(w_vec[k]), v);
  endtask

  task automatic wait_done(int k);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (w_done[k]) break;
      @(posedge clk); #1;
    end
    if (i == 2000) chk($sformatf("wait_done%0d_timeout", k), 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run(int k, logic [15:0] f, logic [15:0] m, logic mid);
    f_r[k] = f;
    m_r[k] = m;
    if (k == 0) q0.push_back(model(f, m, c_H0));
    else        q1.push_back(model(f, m, c_H1));
    start_pulse(k);
    if (mid) begin
      wait_vec(k, 3);
      st[k] = 1'b1;
      @(posedge clk); #1;
      st[k] = 1'b0;
    end
    wait_done(k);
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    f_r[0] = '0; f_r[1] = '0; m_r[0] = '0; m_r[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), int'(w_busy[k]), 0);
      chk($sformatf("rst_done%0d", k), int'(w_done[k]), 0);
      chk($sformatf("rst_vec%0d", k), int'(w_vec[k]), 0);
      check_clear(k, $sformatf("rst%0d", k));
    end
    rst = 1'b0;

    // Clean XOR sweep, injected mismatches at 0101/1100, then restart from DONE
    run(0, 16'h6996, 16'h0000, 1'b0);
    run(0, 16'h6996, 16'h1020, 1'b0);
    run(0, 16'h6996, 16'h0000, 1'b0);
    // start pulse while vec = 3 must not disturb the sweep
    run(0, 16'h6996, 16'h0000, 1'b1);

    // Reset mid-sweep at vec = 7
    f_r[0] = 16'hA5C3; m_r[0] = 16'h0F0F;
    start_pulse(0);
    wait_vec(0, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_vec", int'(w_vec[0]), 0);
    chk("midrst_busy", int'(w_busy[0]), 0);
    chk("midrst_done", int'(w_done[0]), 0);
    check_clear(0, "midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_stays_idle", int'(w_busy[0]), 0);
    run(0, 16'hA5C3, 16'h0F0F, 1'b0);

    // Minimum hold: z = A&B
    run(1, 16'hF000, 16'h0000, 1'b0);

    // Random functions and sparse mismatch masks on both instances
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 2; k++) begin
        logic [15:0] f, m;
        f = 16'($urandom);
        m = (r == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
        run(k, f, m, 1'b0);
      end
    end

    repeat (4) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hw1_vector_sweeper.md
# hw1_vector_sweeper

Sequential stimulus-and-check stage that sits directly upstream of the HW1 four-input combinational function. It drives A, B, C, D through all 16 input combinations in ascending order (ABCD = 0000 to 1111, A = MSB) and holds each vector for a programmable number of cycles. At the end of each hold it samples the gate-level output (z1) and the dataflow output (z2) of the function under test. It reports the captured truth table, a mismatch count and the first failing vector, so the comparison runs in hardware instead of by waveform inspection.

## Interface
Parameters:
- HOLD_CYCLES, default 100: cycles each vector is held. Legal range 1..1024.

Ports:
- clk  input  1  clock. Everything is rising-edge triggered.
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse. Begins a sweep; honoured only in IDLE or DONE.
- A, B, C, D  output  1 each  stimulus bits, registered. A is the MSB of the vector index.
- z1  input  1  gate-level implementation output
- z2  input  1  dataflow implementation output
- busy  output  1  high while sweeping
- done  output  1  high from sweep completion until the next start or rst
- truth_table  output  16  bit v = z1 sampled for vector v
- mismatch_cnt  output  5  number of vectors where z1 != z2 (range 0..16)
- fail_valid  output  1  high once any mismatch has been recorded
- first_fail  output  4  vector index of the first mismatch. Valid only when fail_valid = 1.

## Operation
- States: IDLE, SWEEP, DONE.
- Internal registers:
  - vec[3:0]: current vector, drives {A,B,C,D}
  - hold_cnt: width clog2(HOLD_CYCLES), minimum 1 bit
- IDLE:
  - Outputs: {A,B,C,D} = 0000, busy = 0, done = 0.
  - On start: go to SWEEP, set vec = 0 and hold_cnt = 0, and clear truth_table, mismatch_cnt, fail_valid and first_fail.
- SWEEP:
  - Each cycle where hold_cnt != HOLD_CYCLES-1: increment hold_cnt.
  - In the cycle where hold_cnt == HOLD_CYCLES-1 (the sample cycle):
    - Write z1 into truth_table[vec].
    - If z1 != z2, increment mismatch_cnt.
    - If z1 != z2 and fail_valid = 0, set first_fail = vec and fail_valid = 1.
    - Then, if vec == 15, go to DONE. Otherwise increment vec and set hold_cnt = 0.
- DONE:
  - busy = 0, done = 1. {A,B,C,D} holds 1111.
  - All results hold until start or rst.
  - A start in DONE behaves exactly like a start in IDLE (clears results, begins a new sweep).
- start while in SWEEP is ignored, with no effect on any register.
- z1 and z2 are sampled only in sample cycles. Their values in all other cycles are don't-care.
- vec never wraps past 15. The sweep ends in DONE and does not roll over to 0000.
- mismatch_cnt cannot overflow, because the maximum is 16 and the register is 5 bits.

## Timing
- Reset: on a rising edge with rst = 1, all of the following take effect at that edge, regardless of state (including mid-sweep):
  - state = IDLE
  - A = B = C = D = 0
  - busy = 0, done = 0
  - truth_table = 16'h0000, mismatch_cnt = 0, fail_valid = 0, first_fail = 0
- rst takes priority over start in the same cycle.
- Start latency: start sampled high at edge t gives busy = 1 and ABCD = 0000 after edge t.
- Hold: each vector is presented for exactly HOLD_CYCLES cycles, so vector v occupies cycles [v·HOLD_CYCLES, (v+1)·HOLD_CYCLES) relative to the start edge.
- Sampling: the sample of vector v uses the z1/z2 values present during the last cycle of its hold window. This gives the combinational function under test HOLD_CYCLES-1 cycles to settle.
- Completion: busy stays high for exactly 16·HOLD_CYCLES cycles. done rises on the edge after the vector-15 sample, and busy falls on that same edge.
- Result registers update on the same edge that closes each sample cycle.

## Test plan
- **Clean sweep.** HOLD_CYCLES = 4; z1 = z2 = A^B^C^D. Pulse start.
  - ABCD steps 0000..1111, 4 cycles each.
  - busy is high for 64 cycles, then done = 1.
  - truth_table = 16'h6996, mismatch_cnt = 0, fail_valid = 0.
- **Injected mismatches.** HOLD_CYCLES = 4; z2 = z1 except z2 is inverted when ABCD = 0101 and when ABCD = 1100.
  - mismatch_cnt = 2, fail_valid = 1, first_fail = 4'd5.
- **Start during sweep.** Pulse start again while vec = 3.
  - The sweep is not restarted: vec continues to 4 on schedule.
  - Total busy time is still 64 cycles.
- **Reset mid-sweep.** Assert rst for one cycle while vec = 7.
  - On the next edge: ABCD = 0000, busy = 0, done = 0, truth_table = 0, mismatch_cnt = 0.
  - A subsequent start runs a full, correct sweep.
- **Minimum hold.** HOLD_CYCLES = 1; z1 = A&B, z2 = A&B.
  - Each vector is held for 1 cycle; busy for 16 cycles.
  - truth_table = 16'hF000, mismatch_cnt = 0.
- **Restart from DONE.** After a sweep that ends with mismatch_cnt = 2, pulse start.
  - Results clear on the start edge.
  - A clean second sweep finishes with mismatch_cnt = 0 and fail_valid = 0.
